exec_unit_scheduler: RTL and testbench

Sits between instruction decode and the execution units. It accepts one decoded instruction per cycle through a valid/ready handshake, holds it in a single-entry buffer, and issues it to a free slot of the target class. The classes are 3 AU slots, 3 MUL slots and 1 LSU. The block tracks slot occupancy from issue until the unit's done pulse, and drives the per-class free vectors back to decode.

---
 rtl/exec_unit_scheduler_if.sv | 11 +
 rtl/exec_unit_scheduler.sv | 176 +++++++++++++++++
 tb/tb_exec_unit_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_scheduler_if.sv
// Decode-to-scheduler handshake: one decoded instruction per cycle under valid/ready.
interface exec_unit_scheduler_if;
    logic        valid;
    logic        ready;
    logic [7:0]  execute_type;
    logic [16:0] rd_rs1_rs2;
    logic [31:0] imm;

    modport master (output valid, execute_type, rd_rs1_rs2, imm, input ready);
    modport slave  (input valid, execute_type, rd_rs1_rs2, imm, output ready);
endinterface

// File: rtl/exec_unit_scheduler.sv
// Single-entry issue buffer that dispatches decoded instructions to free AU/MUL/LSU
// slots, tracks slot occupancy until done, and keeps issue/stall counters.

module exec_unit_rr_pick #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] busy,
    input  logic         advance,
    output logic         found,
    output logic [N-1:0] pick
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && !busy[PW'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                sel   = PW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        pick      = '0;
        pick[sel] = found;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst)          ptr <= '0;
        else if (advance) ptr <= PW'((int'(sel) + 1) % N);
    end
endmodule

module exec_unit_scheduler #(
    parameter int N_AU  = 3,
    parameter int N_MUL = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_unit_scheduler_if.slave dec,
    input  logic                 flush,
    input  logic [N_AU-1:0]      au_done,
    input  logic [N_MUL-1:0]     mul_done,
    input  logic                 lsu_done,
    output logic [N_AU-1:0]      au_issue,
    output logic [N_MUL-1:0]     mul_issue,
    output logic                 lsu_issue,
    output logic [4:0]           iss_op,
    output logic [16:0]          iss_rd_rs1_rs2,
    output logic [31:0]          iss_imm,
    output logic [N_AU-1:0]      au_free,
    output logic [N_MUL-1:0]     mul_free,
    output logic                 lsu_free,
    output logic                 err_bad_type,
    output logic                 err_spurious_done,
    output logic [CNT_W-1:0]     issue_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);
    typedef enum logic [1:0] {CLS_AU, CLS_MUL, CLS_LSU, CLS_BAD} cls_e;

    logic              hold_valid;
    logic [7:0]        hold_type;
    logic [16:0]       hold_tags;
    logic [31:0]       hold_imm;
    cls_e              hold_cls;

    logic [N_AU-1:0]   au_busy, au_pick;
    logic [N_MUL-1:0]  mul_busy, mul_pick;
    logic              lsu_busy;
    logic              au_found, mul_found;
    logic              can_go, au_go, mul_go, lsu_go, issue_now, bad_drop, accept;
    logic              just_reset, spurious;

    always_comb begin
        hold_cls = CLS_BAD;
        case (hold_type[7:5])
            3'b100:  hold_cls = CLS_AU;
            3'b010:  hold_cls = CLS_MUL;
            3'b001:  hold_cls = CLS_LSU;
            default: hold_cls = CLS_BAD;
        endcase
    end

    exec_unit_rr_pick #(.N(N_AU)) u_au_rr (
        .clk(clk), .rst(rst), .busy(au_busy), .advance(au_go),
        .found(au_found), .pick(au_pick)
    );

    exec_unit_rr_pick #(.N(N_MUL)) u_mul_rr (
        .clk(clk), .rst(rst), .busy(mul_busy), .advance(mul_go),
        .found(mul_found), .pick(mul_pick)
    );

    // Freedom is judged on registered busy: a slot completing this cycle is reusable next cycle.
    assign can_go    = hold_valid & ~flush;
    assign au_go     = can_go & (hold_cls == CLS_AU) & au_found;
    assign mul_go    = can_go & (hold_cls == CLS_MUL) & mul_found;
    assign lsu_go    = can_go & (hold_cls == CLS_LSU) & ~lsu_busy;
    assign issue_now = au_go | mul_go | lsu_go;
    assign bad_drop  = can_go & (hold_cls == CLS_BAD);

    assign dec.ready = ~flush & (~hold_valid | issue_now | bad_drop);
    assign accept    = dec.valid & dec.ready;

    // Done pulses in the first cycle after reset refer to forgotten work and are ignored.
    assign spurious = ~just_reset & ((|(au_done & ~au_busy)) | (|(mul_done & ~mul_busy)) |
                                     (lsu_done & ~lsu_busy));

    // NOTE: payload registers are qualified by hold_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_type <= dec.execute_type;
            hold_tags <= dec.rd_rs1_rs2;
            hold_imm  <= dec.imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid        <= 1'b0;
            au_busy           <= '0;
            mul_busy          <= '0;
            lsu_busy          <= 1'b0;
            au_issue          <= '0;
            mul_issue         <= '0;
            lsu_issue         <= 1'b0;
            iss_op            <= '0;
            iss_rd_rs1_rs2    <= '0;
            iss_imm           <= '0;
            err_bad_type      <= 1'b0;
            err_spurious_done <= 1'b0;
            issue_cnt         <= '0;
            stall_cnt         <= '0;
            just_reset        <= 1'b1;
        end else begin
            just_reset <= 1'b0;

            if (flush)                     hold_valid <= 1'b0;
            else if (accept)               hold_valid <= 1'b1;
            else if (issue_now | bad_drop) hold_valid <= 1'b0;

            au_busy  <= (au_busy & ~(au_done & {N_AU{~just_reset}})) | (au_go ? au_pick : '0);
            mul_busy <= (mul_busy & ~(mul_done & {N_MUL{~just_reset}})) | (mul_go ? mul_pick : '0);
            lsu_busy <= (lsu_busy & ~(lsu_done & ~just_reset)) | lsu_go;

            au_issue  <= au_go ? au_pick : '0;
            mul_issue <= mul_go ? mul_pick : '0;
            lsu_issue <= lsu_go;
            if (issue_now) begin
                iss_op         <= hold_type[4:0];
                iss_rd_rs1_rs2 <= hold_tags;
                iss_imm        <= hold_imm;
            end

            err_bad_type      <= bad_drop;
            err_spurious_done <= err_spurious_done | spurious;

            issue_cnt <= issue_cnt + CNT_W'(issue_now);
            stall_cnt <= stall_cnt + CNT_W'(can_go & ~issue_now & (hold_cls != CLS_BAD));
        end
    end

    assign au_free  = ~au_busy;
    assign mul_free = ~mul_busy;
    assign lsu_free = ~lsu_busy;
endmodule

// File: tb/tb_exec_unit_scheduler.sv
// Directed and randomized bench for exec_unit_scheduler against a slot-occupancy model.
module tb_exec_unit_scheduler;
    logic        clk = 1'b0;
    logic        rst, flush, lsu_done, lsu_issue, lsu_free, err_bad_type, err_spurious_done;
    logic [2:0]  au_done, mul_done, au_issue, mul_issue, au_free, mul_free;
    logic [4:0]  iss_op;
    logic [16:0] iss_rd_rs1_rs2;
    logic [31:0] iss_imm;
    logic [15:0] issue_cnt, stall_cnt;

    exec_unit_scheduler_if dec_if ();

    exec_unit_scheduler #(.N_AU(3), .N_MUL(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dec(dec_if), .flush(flush),
        .au_done(au_done), .mul_done(mul_done), .lsu_done(lsu_done),
        .au_issue(au_issue), .mul_issue(mul_issue), .lsu_issue(lsu_issue),
        .iss_op(iss_op), .iss_rd_rs1_rs2(iss_rd_rs1_rs2), .iss_imm(iss_imm),
        .au_free(au_free), .mul_free(mul_free), .lsu_free(lsu_free),
        .err_bad_type(err_bad_type), .err_spurious_done(err_spurious_done),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: class 0=AU, 1=MUL, 2=LSU (slot 0 only), 3=invalid.
    bit          m_hv, m_jr, m_bad, m_sp, m_lsu_iss;
    logic [7:0]  m_type;
    logic [16:0] m_tags, m_iss_tags;
    logic [31:0] m_imm, m_iss_imm;
    logic [4:0]  m_op;
    logic [2:0]  m_au_iss, m_mul_iss;
    bit          m_busy[3][3];
    int          m_ptr[3];
    int          m_icnt, m_scnt;
    logic [2:0]  bad_tops[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_class();
        case (m_type[7:5])
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int m_find(input int c);
        if (c == 2) return m_busy[2][0] ? -1 : 0;
        for (int k = 0; k < 3; k++)
            if (!m_busy[c][(m_ptr[c] + k) % 3]) return (m_ptr[c] + k) % 3;
        return -1;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (!m_hv) return 1'b1;
        if (m_class() == 3) return 1'b1;
        return m_find(m_class()) >= 0;
    endfunction

    function automatic logic [2:0] m_free(input int c);
        return ~{m_busy[c][2], m_busy[c][1], m_busy[c][0]};
    endfunction

    task automatic model_step();
        int  c, s;
        bit  issued, bad, rdy;
        if (rst) begin
            m_hv = 0; m_jr = 1; m_bad = 0; m_sp = 0; m_lsu_iss = 0;
            m_au_iss = '0; m_mul_iss = '0; m_op = '0; m_iss_tags = '0; m_iss_imm = '0;
            m_icnt = 0; m_scnt = 0;
            for (int i = 0; i < 3; i++) begin
                m_ptr[i] = 0;
                for (int j = 0; j < 3; j++) m_busy[i][j] = 0;
            end
            return;
        end
        c = m_class(); rdy = m_ready();
        issued = 0; bad = 0; s = -1;
        if (m_hv && !flush) begin
            if (c == 3) bad = 1;
            else begin s = m_find(c); issued = (s >= 0); end
        end
        if (!m_jr) begin
            for (int i = 0; i < 3; i++) begin
                if (au_done[i])  begin if (m_busy[0][i]) m_busy[0][i] = 0; else m_sp = 1; end
                if (mul_done[i]) begin if (m_busy[1][i]) m_busy[1][i] = 0; else m_sp = 1; end
            end
            if (lsu_done) begin if (m_busy[2][0]) m_busy[2][0] = 0; else m_sp = 1; end
        end
        m_au_iss = '0; m_mul_iss = '0; m_lsu_iss = 0;
        if (issued) begin
            m_busy[c][s] = 1;
            m_ptr[c] = (s + 1) % 3;
            if (c == 0) m_au_iss[s] = 1'b1;
            else if (c == 1) m_mul_iss[s] = 1'b1;
            else m_lsu_iss = 1;
            m_op = m_type[4:0]; m_iss_tags = m_tags; m_iss_imm = m_imm;
            m_icnt = (m_icnt + 1) % 65536;
        end
        m_bad = bad;
        if (m_hv && !flush && !issued && !bad) m_scnt = (m_scnt + 1) % 65536;
        if (flush) m_hv = 0;
        else if (dec_if.valid && rdy) begin
            m_hv = 1; m_type = dec_if.execute_type; m_tags = dec_if.rd_rs1_rs2; m_imm = dec_if.imm;
        end else if (issued || bad) m_hv = 0;
        m_jr = 0;
    endtask

    task automatic compare_all();
        check("dec_ready", dec_if.ready, m_ready());
        check("au_issue", au_issue, m_au_iss);
        check("mul_issue", mul_issue, m_mul_iss);
        check("lsu_issue", lsu_issue, m_lsu_iss);
        check("iss_op", iss_op, m_op);
        check("iss_rd_rs1_rs2", iss_rd_rs1_rs2, m_iss_tags);
        check("iss_imm", iss_imm, m_iss_imm);
        check("au_free", au_free, m_free(0));
        check("mul_free", mul_free, m_free(1));
        check("lsu_free", lsu_free, !m_busy[2][0]);
        check("err_bad_type", err_bad_type, m_bad);
        check("err_spurious_done", err_spurious_done, m_sp);
        check("issue_cnt", issue_cnt, m_icnt);
        check("stall_cnt", stall_cnt, m_scnt);
    endtask

    // Compare the current cycle, advance DUT and model across one edge, return at negedge.
    task automatic tick();
        #1 compare_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] ty, input logic [31:0] imm);
        dec_if.valid = 1'b1; dec_if.execute_type = ty;
        dec_if.rd_rs1_rs2 = 17'h1abcd ^ {9'd0, ty}; dec_if.imm = imm;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; au_done = '0; mul_done = '0; lsu_done = 1'b0;
        dec_if.valid = 1'b0; dec_if.execute_type = '0; dec_if.rd_rs1_rs2 = '0; dec_if.imm = '0;
        @(posedge clk); model_step(); @(negedge clk);
        tick();
        check("reset_au_free", au_free, 3'b111);
        check("reset_issue_cnt", issue_cnt, 16'd0);

        // Single AU op, then round-robin moves to slot 1 after slot 0 completes.
        rst = 1'b0;
        send(8'h80, 32'd5); tick();
        dec_if.valid = 1'b0; tick();
        check("au_first_issue", au_issue, 3'b001);
        check("au_first_imm", iss_imm, 32'd5);
        check("au_first_free", au_free, 3'b110);
        check("au_first_cnt", issue_cnt, 16'd1);
        au_done = 3'b001; tick(); au_done = '0;
        check("au_done_free", au_free, 3'b111);
        send(8'h81, 32'd7); tick();
        dec_if.valid = 1'b0; tick();
        check("au_rr_slot1", au_issue, 3'b010);

        // Done pulses right after reset are ignored.
        rst = 1'b1; tick(); rst = 1'b0;
        au_done = 3'b111; tick(); au_done = '0;
        check("post_reset_done_quiet", err_spurious_done, 1'b0);

        // Four MUL ops back to back: three issue, fourth stalls until slot 1 frees.
        send(8'h40, 32'd0); tick();
        send(8'h41, 32'd1); tick();
        check("mul_iss0", mul_issue, 3'b001);
        send(8'h42, 32'd2); tick();
        check("mul_iss1", mul_issue, 3'b010);
        send(8'h43, 32'd3); tick();
        check("mul_iss2", mul_issue, 3'b100);
        dec_if.valid = 1'b0; #1;
        check("mul_full_ready", dec_if.ready, 1'b0);
        tick();
        check("mul_stalled", mul_issue, 3'b000);
        mul_done = 3'b010; tick(); mul_done = '0; tick();
        check("mul_4th_slot1", mul_issue, 3'b010);
        check("mul_4th_op", iss_op, 5'd3);
        check("mul_stall_cnt", stall_cnt, 16'd2);
        check("mul_issue_cnt", issue_cnt, 16'd4);

        // Flush while MUL is full: held op is dropped for good.
        send(8'h44, 32'd4); tick();
        dec_if.valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
        mul_done = 3'b111; tick(); mul_done = '0;
        tick(); tick(); tick();
        check("flush_no_issue_cnt", issue_cnt, 16'd4);
        check("flush_mul_free", mul_free, 3'b111);

        // Invalid class is consumed with an error pulse; done on idle slot is sticky.
        send(8'hC0, 32'd9); tick();
        dec_if.valid = 1'b0; #1;
        check("bad_ready", dec_if.ready, 1'b1);
        tick();
        check("bad_pulse", err_bad_type, 1'b1);
        check("bad_no_issue", issue_cnt, 16'd4);
        tick();
        check("bad_pulse_end", err_bad_type, 1'b0);
        au_done = 3'b100; tick(); au_done = '0;
        check("spurious_set", err_spurious_done, 1'b1);
        tick();
        check("spurious_sticky", err_spurious_done, 1'b1);

        // LSU busy: second load waits until done, then issues one cycle after free.
        send(8'h20, 32'd1); tick();
        send(8'h22, 32'd2); tick();
        check("lsu_first", lsu_issue, 1'b1);
        dec_if.valid = 1'b0; lsu_done = 1'b1; tick(); lsu_done = 1'b0;
        check("lsu_free_again", lsu_free, 1'b1);
        check("lsu_not_yet", lsu_issue, 1'b0);
        tick();
        check("lsu_second", lsu_issue, 1'b1);
        check("lsu_second_op", iss_op, 5'd2);

        // Randomized traffic, including flushes and mid-flight resets.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] op;
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 15) == 0);
            op    = 5'($urandom_range(0, 31));
            dec_if.valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: dec_if.execute_type = {3'b100, op};
                1: dec_if.execute_type = {3'b010, op};
                2: dec_if.execute_type = {3'b001, op};
                default: dec_if.execute_type = {bad_tops[$urandom_range(0, 4)], op};
            endcase
            dec_if.rd_rs1_rs2 = 17'($urandom);
            dec_if.imm = $urandom;
            for (int i = 0; i < 3; i++) begin
                au_done[i]  = (m_busy[0][i] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
                mul_done[i] = (m_busy[1][i] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
            end
            lsu_done = (m_busy[2][0] && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; au_done = '0; mul_done = '0; lsu_done = 1'b0;

        // Reset with work in flight.
        send(8'h80, 32'd1); tick(); send(8'h40, 32'd2); tick();
        dec_if.valid = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("midreset_au_free", au_free, 3'b111);
        check("midreset_mul_free", mul_free, 3'b111);
        check("midreset_lsu_free", lsu_free, 1'b1);
        check("midreset_issue_cnt", issue_cnt, 16'd0);
        check("midreset_stall_cnt", stall_cnt, 16'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
